// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the encrypt and decrypt datapaths.
// Byte b of a 128-bit state sits at [8*(15-b) +: 8], column-major as in FIPS-197.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_EXPAND, S_ADDKEY, S_ROUND, S_FINAL, S_DONE
  } dec_state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] rk, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon(i), 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+4-r)%4)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++) o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule: round key i -> round key i-1.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [3:0]   round,
  output logic [127:0] rk_prev
);

  logic [31:0] w0_n, w1_n, w2_n, w3_n;

  // Undo the forward chain from the last word back; w0 needs the recovered w3.
  always_comb begin
    w3_n = rk_i[31:0] ^ rk_i[63:32];
    w2_n = rk_i[63:32] ^ rk_i[95:64];
    w1_n = rk_i[95:64] ^ rk_i[127:96];
    w0_n = rk_i[127:96] ^ sub_word(rot_word(w3_n)) ^ {rcon(round), 24'h0};
    rk_prev = {w0_n, w1_n, w2_n, w3_n};
  end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock; the round-10 key is derived
// by forward expansion and then walked back round by round, so no key table is stored.
module aes_128_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         ready,
  output logic         busy
);

  dec_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic [127:0] rk_prev;
  logic [3:0]   step_round;

  // In ROUND the counter holds r while the key register still holds rk_{r+1}.
  assign step_round = cnt_q + 4'd1;

  aes_inv_key_step u_inv_key_step (
    .rk_i    (key_q),
    .round   (step_round),
    .rk_prev (rk_prev)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    key_d   = key_q;
    out_d   = out_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          data_d  = in;
          key_d   = key;
          cnt_d   = 4'd1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        key_d = fwd_key_step(key_q, cnt_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NR) state_d = S_ADDKEY;
      end
      S_ADDKEY: begin
        data_d  = data_q ^ key_q;
        cnt_d   = NR - 4'd1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        key_d  = rk_prev;
        data_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_prev);
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        key_d   = rk_prev;
        out_d   = inv_sub_bytes(inv_shift_rows(data_q)) ^ rk_prev;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      key_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      key_q   <= key_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Bench for aes_128_decrypt: known-answer table, start/reset corner cases, and
// random loopback through an independent forward-cipher model.
module tb_aes_128_decrypt;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] in_v, key_v, out_v;
  logic         ready, busy;

  always #5 clk = ~clk;

  aes_128_decrypt dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_v),
    .key   (key_v),
    .out   (out_v),
    .ready (ready),
    .busy  (busy)
  );

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Forward AES-128 reference cipher.
  function automatic logic [127:0] tb_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] rk, s, t;
    logic [31:0]  tmp, w0, w1, w2, w3;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = k;
    s  = pt ^ rk;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = {rk[23:0], rk[31:24]};
      tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
      w0 = rk[127:96] ^ tmp;
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[8*(15-(4*c+row)) +: 8] = sbox(s[8*(15-(4*((c+row)%4)+row)) +: 8]);
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[32*(3-c) +: 32];
          t[32*(3-c) +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic run_op(input string name, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt);
    int cyc;
    in_v  = ct;
    key_v = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    sb_q.push_back(pt);
    check({name, " busy after accept"}, 128'(busy), 128'd1);
    check({name, " ready after accept"}, 128'(ready), 128'd0);
    cyc = 0;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check({name, " latency"}, 128'(cyc), 128'd21);
    check({name, " out"}, out_v, sb_q.pop_front());
    check({name, " busy at ready"}, 128'(busy), 128'd0);
    check({name, " rk0 restored"}, dut.key_q, k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[4];
    logic [127:0] k, pt, exp;
    int           err;

    vecs[0] = '{"C.1", C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{"App B", B_KEY, B_CT, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{"zero key", '0, Z_CT, '0};
    vecs[3] = '{"sp800-38a", B_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    in_v  = '0;
    key_v = '0;
    do_reset();
    check("reset out", out_v, '0);
    check("reset ready", 128'(ready), 128'd0);
    check("reset busy", 128'(busy), 128'd0);

    check("model C.1 encrypt", tb_encrypt(C1_KEY, C1_PT), C1_CT);

    for (int i = 0; i < 4; i++) run_op(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt);

    // start held high: accepted only in DONE, one-cycle ready every 22 cycles
    key_v = '0;
    in_v  = Z_CT;
    start = 1'b1;
    tick();
    sb_q.push_back('0);
    err = 0;
    for (int t = 1; t <= 66; t++) begin
      tick();
      if (ready !== ((t % 22) == 21)) err++;
      if (ready) begin
        check("held start out", out_v, sb_q.pop_front());
        sb_q.push_back('0);
      end
    end
    check("held start ready pattern", 128'(err), 128'd0);
    start = 1'b0;
    sb_q.delete();
    do_reset();

    // start pulses while busy must be ignored
    in_v  = C1_CT;
    key_v = C1_KEY;
    start = 1'b1;
    tick();
    sb_q.push_back(C1_PT);
    err = 0;
    for (int t = 1; t <= 22; t++) begin
      start = (t == 3 || t == 10 || t == 20);
      in_v  = start ? B_CT : C1_CT;
      key_v = start ? B_KEY : C1_KEY;
      tick();
      start = 1'b0;
      if (t < 21 && ready) err++;
      if (t == 21) begin
        check("ignore ready", 128'(ready), 128'd1);
        check("ignore out", out_v, sb_q.pop_front());
      end
      if (t == 22) check("ready held in DONE", 128'(ready), 128'd1);
    end
    check("ignore early ready", 128'(err), 128'd0);

    // reset at edge +12 aborts the operation
    in_v  = B_CT;
    key_v = B_KEY;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 11; t++) tick();
    reset = 1'b1;
    tick();
    check("mid reset out", out_v, '0);
    check("mid reset ready", 128'(ready), 128'd0);
    check("mid reset busy", 128'(busy), 128'd0);
    reset = 1'b0;
    err = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (ready || busy) err++;
    end
    check("no result after reset", 128'(err), 128'd0);
    run_op("C.1 after reset", C1_KEY, C1_CT, C1_PT);

    for (int i = 0; i < 200; i++) begin
      k   = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      exp = tb_encrypt(k, pt);
      run_op("loopback", k, exp, pt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
